// File: rtl/sram_arbiter_nch.sv
// Shares one async SRAM among NUM_CH requesters: sync select edges, pick a channel, run a fixed-length access.
// Grant to next grant is ACCESS_TICKS+2 clocks; requests arriving while busy queue as pending and merge (overrun).
module sram_arbiter_nch #(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int ACCESS_TICKS = 3,
  parameter int PRIO_MODE    = 0,
  parameter int SYNC_STAGES  = 3
) (
  input  logic                       clock_50,
  input  logic                       reset_n,
  input  logic [NUM_CH-1:0]          ch_sel_n,
  input  logic [NUM_CH-1:0]          ch_enable,
  input  logic [NUM_CH-1:0]          ch_rw,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  output logic [NUM_CH*DATA_W-1:0]   ch_rdata,
  output logic [NUM_CH-1:0]          ch_done,
  output logic [NUM_CH-1:0]          ch_pending,
  output logic [NUM_CH-1:0]          ch_overrun,
  input  logic [NUM_CH-1:0]          ch_overrun_clr,
  output logic [ADDR_W-1:0]          sram_addrbus,
  inout  wire  [DATA_W-1:0]          sram_databus,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RECOVER} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [SYNC_STAGES-1:0]     r_sync [NUM_CH];
  logic [NUM_CH-1:0]          r_pending;
  logic [NUM_CH-1:0]          r_overrun;
  logic [NUM_CH-1:0]          r_done;
  logic [NUM_CH*DATA_W-1:0]   r_rdata;
  logic [CH_W-1:0]            r_ptr;
  logic [CH_W-1:0]            r_gnt;
  logic [ADDR_W-1:0]          r_addr;
  logic                       r_rw;
  logic [DATA_W-1:0]          r_wdata;
  logic [3:0]                 r_cnt;

  logic [NUM_CH-1:0]          w_edge;
  logic [NUM_CH-1:0]          w_gnt_oh;
  logic [CH_W-1:0]            w_gnt;
  logic [CH_W-1:0]            w_idx;
  logic                       w_grant;
  logic                       w_drive;

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) r_sync[i] <= '1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], ch_sel_n[i]};
    end
  end

  // Falling edge of the select: newer stage already low, oldest stage still high.
  always_comb begin
    w_edge = '0;
    for (int i = 0; i < NUM_CH; i++)
      w_edge[i] = ch_enable[i] & ~r_sync[i][SYNC_STAGES-2] & r_sync[i][SYNC_STAGES-1];
  end

  always_comb begin
    w_gnt = '0;
    w_idx = '0;
    if (PRIO_MODE == 0) begin
      for (int i = 0; i < NUM_CH; i++)
        if (r_pending[i]) w_gnt = CH_W'(i);
    end else begin
      // Scan downward so the nearest index after the pointer is the last to win.
      for (int k = NUM_CH; k >= 1; k--) begin
        w_idx = CH_W'((int'(r_ptr) + k) % NUM_CH);
        if (r_pending[w_idx]) w_gnt = w_idx;
      end
    end
  end

  assign w_grant  = (r_state == S_IDLE) && (|r_pending);
  assign w_gnt_oh = w_grant ? (NUM_CH'(1) << w_gnt) : '0;

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_pending <= (r_pending & ~w_gnt_oh) | w_edge;
      r_overrun <= (r_overrun & ~ch_overrun_clr) | (w_edge & r_pending & ~w_gnt_oh);
    end
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    sram_ce_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    w_drive     = 1'b0;
    case (r_state)
      S_IDLE:    if (|r_pending) w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        sram_ce_n = 1'b0;
        sram_oe_n = ~r_rw;
        sram_we_n = r_rw;
        w_drive   = ~r_rw;
        if (r_cnt == 4'd0) w_state_nxt = S_RECOVER;
      end
      S_RECOVER: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr   <= CH_W'(NUM_CH - 1);
      r_gnt   <= '0;
      r_addr  <= '0;
      r_rw    <= 1'b1;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_done  <= '0;
    end else begin
      r_done <= '0;
      if (w_grant) begin
        r_gnt   <= w_gnt;
        r_addr  <= ch_addr[int'(w_gnt)*ADDR_W +: ADDR_W];
        r_rw    <= ch_rw[w_gnt];
        r_wdata <= ch_wdata[int'(w_gnt)*DATA_W +: DATA_W];
        r_cnt   <= 4'(ACCESS_TICKS - 1);
        if (PRIO_MODE != 0) r_ptr <= w_gnt;
      end
      if (r_state == S_ACCESS) begin
        if (r_cnt == 4'd0) begin
          if (r_rw) r_rdata[int'(r_gnt)*DATA_W +: DATA_W] <= sram_databus;
          r_done <= NUM_CH'(1) << r_gnt;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign sram_databus = w_drive ? r_wdata : 'z;
  assign sram_addrbus = r_addr;
  assign ch_rdata     = r_rdata;
  assign ch_done      = r_done;
  assign ch_pending   = r_pending;
  assign ch_overrun   = r_overrun;

endmodule

// File: tb/tb_sram_arbiter_nch.sv
// Bench for sram_arbiter_nch: instance 0 fixed priority / 3 ticks, instance 1 round robin / 15 ticks.
// Each access pushes its expected channel, data and completion cycle; the done monitor pops and compares.
module tb_sram_arbiter_nch;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [2:0]  sel_n [2];
  logic [2:0]  en    [2];
  logic [2:0]  rw    [2];
  logic [2:0]  oclr  [2];
  logic [2:0]  done  [2];
  logic [2:0]  pend  [2];
  logic [2:0]  ovr   [2];
  logic [47:0] addr  [2];
  logic [23:0] wdata [2];
  logic [23:0] rdata [2];
  logic [15:0] abus  [2];
  logic        ce_n  [2];
  logic        oe_n  [2];
  logic        we_n  [2];
  wire  [7:0]  bus0;
  wire  [7:0]  bus1;

  logic [7:0]  mem0 [0:65535];
  logic [7:0]  mem1 [0:65535];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int cecnt [2];
  logic [7:0] last_wbus [2];

  typedef struct {
    int         inst;
    int         ch;
    bit         rd;
    logic [7:0] data;
    int         at;
  } exp_t;
  exp_t sb [$];

  sram_arbiter_nch #(.NUM_CH(3), .ADDR_W(16), .DATA_W(8), .ACCESS_TICKS(3),
                     .PRIO_MODE(0), .SYNC_STAGES(3)) u_dut_fp (
    .clock_50(clk), .reset_n(reset_n),
    .ch_sel_n(sel_n[0]), .ch_enable(en[0]), .ch_rw(rw[0]),
    .ch_addr(addr[0]), .ch_wdata(wdata[0]), .ch_rdata(rdata[0]),
    .ch_done(done[0]), .ch_pending(pend[0]), .ch_overrun(ovr[0]),
    .ch_overrun_clr(oclr[0]), .sram_addrbus(abus[0]), .sram_databus(bus0),
    .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0])
  );

  sram_arbiter_nch #(.NUM_CH(3), .ADDR_W(16), .DATA_W(8), .ACCESS_TICKS(15),
                     .PRIO_MODE(1), .SYNC_STAGES(3)) u_dut_rr (
    .clock_50(clk), .reset_n(reset_n),
    .ch_sel_n(sel_n[1]), .ch_enable(en[1]), .ch_rw(rw[1]),
    .ch_addr(addr[1]), .ch_wdata(wdata[1]), .ch_rdata(rdata[1]),
    .ch_done(done[1]), .ch_pending(pend[1]), .ch_overrun(ovr[1]),
    .ch_overrun_clr(oclr[1]), .sram_addrbus(abus[1]), .sram_databus(bus1),
    .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1])
  );

  // Asynchronous SRAM models
  assign bus0 = (!ce_n[0] && !oe_n[0]) ? mem0[abus[0]] : 8'hzz;
  assign bus1 = (!ce_n[1] && !oe_n[1]) ? mem1[abus[1]] : 8'hzz;
  always @(posedge clk) if (!ce_n[0] && !we_n[0]) mem0[abus[0]] <= bus0;
  always @(posedge clk) if (!ce_n[1] && !we_n[1]) mem1[abus[1]] <= bus1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ticks(input int d);
    return (d == 0) ? 3 : 15;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] mon_bus;
  logic       mon_z;
  exp_t       mon_e;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mon_bus = (d == 0) ? bus0 : bus1;
      if (!reset_n) begin
        cecnt[d] = 0;
      end else if (!ce_n[d]) begin
        cecnt[d]++;
        chk("strobe_excl", 32'(oe_n[d] ^ we_n[d]), 32'd1);
        if (!we_n[d]) last_wbus[d] = mon_bus;
      end else if (cecnt[d] != 0) begin
        chk("ce_len", 32'(cecnt[d]), 32'(ticks(d)));
        mon_z = (mon_bus === 8'hzz) || (mon_bus === 8'h00);
        chk("recover_bus_z", 32'(mon_z), 32'd1);
        cecnt[d] = 0;
      end
      if (reset_n && done[d] != 3'b000) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done[d]), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("done_inst", 32'(d), 32'(mon_e.inst));
          chk("done_ch", 32'(done[d]), 32'(3'b001 << mon_e.ch));
          chk("done_cycle", 32'(cyc), 32'(mon_e.at));
          if (mon_e.rd) chk("rdata", 32'(rdata[d][mon_e.ch*8 +: 8]), 32'(mon_e.data));
          else          chk("write_bus", 32'(last_wbus[d]), 32'(mon_e.data));
        end
      end
    end
  end

  task automatic pulse(input int d, input logic [2:0] m, output int c0);
    @(posedge clk); #1;
    sel_n[d] = sel_n[d] & ~m;
    c0 = cyc;
    repeat (2) @(posedge clk);
    #1;
    sel_n[d] = sel_n[d] | m;
  endtask

  task automatic setup(input int d, input int ch, input logic r, input logic [15:0] a,
                       input logic [7:0] wd);
    rw[d][ch] = r;
    addr[d][ch*16 +: 16] = a;
    wdata[d][ch*8 +: 8] = wd;
  endtask

  task automatic push(input int inst, input int ch, input bit rd, input logic [7:0] data,
                      input int at);
    exp_t e;
    e = '{inst, ch, rd, data, at};
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk({"drain_", tag}, 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int d, input int ch);
    int n = 0;
    while (done[d][ch] !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_done", 32'(done[d][ch]), 32'd1);
  endtask

  task automatic wait_ce(input int d);
    int n = 0;
    while (ce_n[d] !== 1'b0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_ce", 32'(ce_n[d]), 32'd0);
  endtask

  task automatic wait_we(input int d);
    int n = 0;
    while (we_n[d] !== 1'b0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_we", 32'(we_n[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

  int c0;
  int cx;

  initial begin
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      sel_n[d] = 3'b111; en[d] = 3'b111; rw[d] = 3'b111; oclr[d] = 3'b000;
      addr[d] = '0; wdata[d] = '0; cecnt[d] = 0; last_wbus[d] = 8'h00;
    end
    mem0[16'h2000] = 8'hA5;
    mem0[16'h1233] = 8'h11;
    mem0[16'h1235] = 8'h22;
    for (int i = 0; i < 3; i++) begin
      mem0[16'h0010 + 16'(i)] = 8'h30 + 8'(i);
      mem1[16'h0040 + 16'(i)] = 8'h50 + 8'(i);
      mem1[16'h0060 + 16'(i)] = 8'h70 + 8'(i);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ce_n", 32'(ce_n[d]), 32'd1);
      chk("rst_oe_n", 32'(oe_n[d]), 32'd1);
      chk("rst_we_n", 32'(we_n[d]), 32'd1);
      chk("rst_addrbus", 32'(abus[d]), 32'd0);
      chk("rst_rdata", 32'(rdata[d]), 32'd0);
      chk("rst_pending", 32'(pend[d]), 32'd0);
      chk("rst_overrun", 32'(ovr[d]), 32'd0);
      chk("rst_done", 32'(done[d]), 32'd0);
    end
    mon_z = (bus0 === 8'hzz) || (bus0 === 8'h00);
    chk("rst_bus_z", 32'(mon_z), 32'd1);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Read: two sync clocks, pending, grant, then three access clocks
    setup(0, 0, 1'b1, 16'h2000, 8'h00);
    pulse(0, 3'b001, c0);
    push(0, 0, 1'b1, 8'hA5, c0 + 7);
    drain("read");
    chk("read_addrbus_held", 32'(abus[0]), 32'h2000);
    chk("read_others_rdata", 32'(rdata[0][23:8]), 32'd0);

    // Write then readback on channel 1
    setup(0, 1, 1'b0, 16'h8001, 8'h5C);
    pulse(0, 3'b010, c0);
    push(0, 1, 1'b0, 8'h5C, c0 + 7);
    drain("write");
    chk("write_mem", 32'(mem0[16'h8001]), 32'h5C);
    setup(0, 1, 1'b1, 16'h8001, 8'h00);
    pulse(0, 3'b010, c0);
    push(0, 1, 1'b1, 8'h5C, c0 + 7);
    drain("readback");
    chk("readback_ch0_kept", 32'(rdata[0][7:0]), 32'hA5);

    // Fixed priority: simultaneous requests served highest index first
    for (int i = 0; i < 3; i++) setup(0, i, 1'b1, 16'h0010 + 16'(i), 8'h00);
    pulse(0, 3'b111, c0);
    push(0, 2, 1'b1, 8'h32, c0 + 7);
    push(0, 1, 1'b1, 8'h31, c0 + 12);
    push(0, 0, 1'b1, 8'h30, c0 + 17);
    drain("fixed_prio");
    chk("fixed_prio_overrun", 32'(ovr[0]), 32'd0);

    // Gated channel: edge ignored
    en[0] = 3'b101;
    pulse(0, 3'b010, c0);
    repeat (6) @(posedge clk);
    #1;
    chk("gated_pending", 32'(pend[0]), 32'd0);
    en[0] = 3'b111;
    repeat (4) @(posedge clk);
    #1;
    chk("gated_no_pending_after", 32'(pend[0]), 32'd0);

    // Round robin with continuous re-requests
    for (int i = 0; i < 3; i++) setup(1, i, 1'b1, 16'h0040 + 16'(i), 8'h00);
    pulse(1, 3'b111, c0);
    push(1, 0, 1'b1, 8'h50, c0 + 19);
    push(1, 1, 1'b1, 8'h51, c0 + 36);
    push(1, 2, 1'b1, 8'h52, c0 + 53);
    for (int i = 0; i < 3; i++) begin
      wait_done(1, i);
      pulse(1, 3'b001 << i, cx);
      push(1, i, 1'b1, 8'h50 + 8'(i), c0 + 19 + 17 * (3 + i));
    end
    drain("round_robin");
    chk("rr_overrun", 32'(ovr[1]), 32'd0);

    // Overrun: two ch2 edges behind a long ch0 access merge into one access
    setup(1, 0, 1'b1, 16'h0060, 8'h00);
    setup(1, 2, 1'b1, 16'h0062, 8'h00);
    pulse(1, 3'b001, c0);
    push(1, 0, 1'b1, 8'h70, c0 + 19);
    push(1, 2, 1'b1, 8'h72, c0 + 36);
    wait_ce(1);
    pulse(1, 3'b100, cx);
    pulse(1, 3'b100, cx);
    repeat (2) @(posedge clk);
    #1;
    chk("ovr_flag", 32'(ovr[1]), 32'b100);
    chk("ovr_pending", 32'(pend[1]), 32'b100);
    drain("overrun");
    repeat (20) @(posedge clk);
    #1;
    chk("ovr_sticky", 32'(ovr[1]), 32'b100);
    chk("ovr_pending_clear", 32'(pend[1]), 32'd0);
    oclr[1] = 3'b100;
    @(posedge clk); #1;
    oclr[1] = 3'b000;
    chk("ovr_cleared", 32'(ovr[1]), 32'd0);

    // Reset in the second clock of a write access
    setup(0, 0, 1'b0, 16'h1234, 8'h77);
    pulse(0, 3'b001, c0);
    wait_we(0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ce_n", 32'(ce_n[0]), 32'd1);
    chk("mid_rst_oe_n", 32'(oe_n[0]), 32'd1);
    chk("mid_rst_we_n", 32'(we_n[0]), 32'd1);
    mon_z = (bus0 === 8'hzz) || (bus0 === 8'h00);
    chk("mid_rst_bus_z", 32'(mon_z), 32'd1);
    chk("mid_rst_pending", 32'(pend[0]), 32'd0);
    chk("mid_rst_done", 32'(done[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_rdata", 32'(rdata[0]), 32'd0);
    chk("mid_rst_mem_2000", 32'(mem0[16'h2000]), 32'hA5);
    chk("mid_rst_mem_8001", 32'(mem0[16'h8001]), 32'h5C);
    chk("mid_rst_mem_1233", 32'(mem0[16'h1233]), 32'h11);
    chk("mid_rst_mem_1235", 32'(mem0[16'h1235]), 32'h22);
    chk("mid_rst_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter_nch.md
Name: sram_arbiter_nch

Overview:
- Parametrised successor to the FDC bridge's SRAM sharing logic: arbitrates one asynchronous SRAM among NUM_CH slow requesters (CoCo CTS, CoCo SCS, AVR and later ones).
- Each requester gets:
  - a synchronised select strobe;
  - a pending flag;
  - a held read buffer;
  - a done pulse.
- Adds a selectable priority mode, a configurable access length, a bus-turnaround cycle and per-channel overrun detection.

Parameters:
- NUM_CH, 3, number of requester channels (1..8)
- ADDR_W, 16, SRAM address width
- DATA_W, 8, SRAM data width
- ACCESS_TICKS, 3, clocks per SRAM access (1..15)
- PRIO_MODE, 0, 0 = fixed priority (highest index wins), 1 = round robin
- SYNC_STAGES, 3, synchroniser depth per select (>=3)

Ports:
- clock_50  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ch_sel_n  in  NUM_CH  per-channel select strobe, asynchronous, active low
- ch_enable  in  NUM_CH  per-channel gate; select edges ignored while 0 (e.g. c_power)
- ch_rw  in  NUM_CH  1 = read, 0 = write
- ch_addr  in  NUM_CH*ADDR_W  channel i at [i*ADDR_W +: ADDR_W]
- ch_wdata  in  NUM_CH*DATA_W  write data, same packing
- ch_rdata  out  NUM_CH*DATA_W  held read buffers
- ch_done  out  NUM_CH  one-cycle pulse at access completion
- ch_pending  out  NUM_CH  request queued, not yet granted
- ch_overrun  out  NUM_CH  sticky; a new edge arrived while still pending
- ch_overrun_clr  in  NUM_CH  synchronous clear of ch_overrun
- sram_addrbus  out  ADDR_W  SRAM address
- sram_databus  inout  DATA_W  SRAM data
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active low

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; all pending, done and overrun flags 0.
  - ch_rdata 0; sram_addrbus 0; sram_ce_n, sram_oe_n, sram_we_n all 1; sram_databus Z.
  - Round-robin pointer = NUM_CH-1, so channel 0 is searched first.
  - Reset mid-access aborts immediately; no done pulse; no rdata update.
- Sync and request capture:
  - Each ch_sel_n passes through a SYNC_STAGES flop chain.
  - Falling edge detect: stage[S-2]=0 and stage[S-1]=1.
  - On a detected edge with ch_enable[i]=1, pending[i] is set on that clock.
  - Edge while pending[i]=1 and channel not granted this cycle: ch_overrun[i] is set; pending stays 1; the request is merged.
  - Edge in the same cycle the channel is granted: pending[i] is set again (set wins over clear); no overrun.
  - ch_overrun_clr[i] clears the flag; a simultaneous set wins.
- FSM: IDLE -> ACCESS -> RECOVER -> IDLE.
  - IDLE: if any pending bit is set, choose grant g.
    - PRIO_MODE 0: highest set index wins.
    - PRIO_MODE 1: first set index after the pointer, modulo NUM_CH; pointer <= g.
    - On the grant clock, latch ch_addr[g] -> sram_addrbus, ch_rw[g], ch_wdata[g]; clear pending[g]; load counter = ACCESS_TICKS-1; go to ACCESS.
  - ACCESS:
    - sram_ce_n=0 throughout.
    - Read: sram_oe_n=0, sram_we_n=1, data bus Z.
    - Write: sram_we_n=0, sram_oe_n=1, data bus driven with latched wdata.
    - Counter decrements each clock.
    - On the clock where counter=0: read captures sram_databus into ch_rdata[g]; ch_done[g] pulses the following cycle; go to RECOVER.
  - RECOVER: one clock; all strobes 1; bus Z; sram_addrbus held. Then IDLE.
- Timing:
  - Access occupancy is ACCESS_TICKS+2 clocks from grant to the next possible grant.
  - ch_rdata[g] is valid when ch_done[g] is high and holds until the next read by channel g.
- Bus safety: sram_databus is driven only in ACCESS with a write; never drive while sram_oe_n=0.
- ch_rdata of non-granted channels never changes.

Test Plan:
- Reset, then read: channel 0 read at addr 0x2000, SRAM model holds 0xA5 -> after sync latency plus 3 clocks ACCESS, ch_rdata[0]=0xA5, ch_done[0] one cycle, ce_n/oe_n low exactly 3 clocks, RECOVER 1 clock.
- Write then readback: ch1 write 0x5C to 0x8001, then ch1 read 0x8001 -> we_n low 3 clocks with bus=0x5C; readback returns 0x5C; bus Z during RECOVER.
- Fixed priority: PRIO_MODE=0, ch0/ch1/ch2 edges in the same clock -> grant order 2,1,0, each separated by 5 clocks.
- Round robin: PRIO_MODE=1, all three channels re-requesting continuously -> grants 0,1,2,0,1,2; no channel starved.
- Overrun and gating:
  - Two ch2 edges while ch2 is blocked behind a long ch0 access (ACCESS_TICKS=15) -> ch_overrun[2]=1, a single ch2 access, overrun cleared by ch_overrun_clr[2].
  - Edge with ch_enable=0 -> no pending.
- Reset mid-write: reset_n low on the 2nd ACCESS clock -> strobes 1 and bus Z immediately; no ch_done; pending 0; SRAM contents other than the target unchanged.
